// File: rtl/instr_stream_pkg.sv
// ============================================================================
// instr_stream_pkg : shared defaults and state encoding for the instruction
//                    stream source.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_stream_pkg;

    localparam int DEF_IWIDTH = 32;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_LW     = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_stream_if.sv
// ============================================================================
// instr_stream_if : burst request, stream handshake and memory load port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_stream_if
    import instr_stream_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int AW     = addr_bits(DEF_DEPTH),
    parameter int LW     = DEF_LW
);
    logic              t_i_req;
    logic [AW-1:0]     t_i_base;
    logic [LW-1:0]     t_i_len;
    logic              t_i_abort;
    logic              t_i_ready;
    logic [IWIDTH-1:0] t_o_instr;
    logic              t_o_valid;
    logic              t_o_last;
    logic              t_o_busy;
    logic              t_o_err;
    logic              t_i_wr_en;
    logic [AW-1:0]     t_i_wr_addr;
    logic [IWIDTH-1:0] t_i_wr_data;

    modport master (
        output t_i_req, t_i_base, t_i_len, t_i_abort, t_i_ready,
        output t_i_wr_en, t_i_wr_addr, t_i_wr_data,
        input  t_o_instr, t_o_valid, t_o_last, t_o_busy, t_o_err
    );

    modport slave (
        input  t_i_req, t_i_base, t_i_len, t_i_abort, t_i_ready,
        input  t_i_wr_en, t_i_wr_addr, t_i_wr_data,
        output t_o_instr, t_o_valid, t_o_last, t_o_busy, t_o_err
    );
endinterface

`default_nettype wire

// File: rtl/instr_mem.sv
// ============================================================================
// instr_mem : synchronous-write, registered-read instruction memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_mem
    import instr_stream_pkg::*;
#(
    parameter int    IWIDTH    = DEF_IWIDTH,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter int    AW        = addr_bits(DEPTH),
    parameter string INIT_FILE = "./source/instr.txt"
) (
    input  wire logic              t_clk,
    input  wire logic              t_rst,
    input  wire logic              i_wr_en,
    input  wire logic [AW-1:0]     i_wr_addr,
    input  wire logic [IWIDTH-1:0] i_wr_data,
    input  wire logic              i_rd_en,
    input  wire logic [AW-1:0]     i_rd_addr,
    output logic      [IWIDTH-1:0] o_rd_data
);
    logic [IWIDTH-1:0] r_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
    end

    // The array itself is never reset; only the read register is.
    always_ff @(posedge t_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst)       o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

`default_nettype wire

// File: rtl/instr_stream.sv
// ============================================================================
// instr_stream : burst instruction source with valid/ready output, wrap or
//                truncate addressing, abort and a memory load port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_stream
    import instr_stream_pkg::*;
#(
    parameter int    IWIDTH    = DEF_IWIDTH,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter int    AW        = addr_bits(DEPTH),
    parameter int    LW        = DEF_LW,
    parameter int    WRAP      = 1,
    parameter string INIT_FILE = "./source/instr.txt"
) (
    input  wire logic         t_clk,
    input  wire logic         t_rst,
    instr_stream_if.slave     bus
);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_rem;
    logic            r_valid;
    logic            r_last;
    logic            r_err;

    logic            w_idle;
    logic            w_xfer;
    logic            w_req_ok;
    logic            w_wr_ok;
    logic            w_err;
    logic            w_rd_en;
    logic [AW-1:0]   w_next_addr;
    logic [AW-1:0]   w_rd_addr;

    function automatic logic f_is_last(input logic [AW-1:0] a, input logic [LW-1:0] r);
        return (r == LW'(1)) || ((WRAP == 0) && (a == C_LAST_ADDR));
    endfunction

    assign w_idle      = (r_state == ST_IDLE);
    assign w_xfer      = r_valid && bus.t_i_ready;
    assign w_req_ok    = (bus.t_i_len != '0) && (32'(bus.t_i_base) < DEPTH);
    assign w_wr_ok     = bus.t_i_wr_en && w_idle && (32'(bus.t_i_wr_addr) < DEPTH);
    assign w_err       = (w_idle && bus.t_i_req && !w_req_ok) || (bus.t_i_wr_en && !w_wr_ok);
    assign w_next_addr = (r_addr == C_LAST_ADDR) ? '0 : r_addr + 1'b1;

    // First read happens one cycle after acceptance, so a same-cycle write lands first.
    assign w_rd_en   = !w_idle && !bus.t_i_abort && (!r_valid || (w_xfer && !r_last));
    assign w_rd_addr = r_valid ? w_next_addr : r_addr;

    instr_mem #(
        .IWIDTH    (IWIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .t_clk     (t_clk),
        .t_rst     (t_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (bus.t_i_wr_addr),
        .i_wr_data (bus.t_i_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (bus.t_o_instr)
    );

    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            case (r_state)
                ST_IDLE: begin
                    if (bus.t_i_req && w_req_ok) begin
                        r_addr  <= bus.t_i_base;
                        r_rem   <= bus.t_i_len;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (bus.t_i_abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_last  <= f_is_last(r_addr, r_rem);
                    end else if (w_xfer) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_rem  <= r_rem - LW'(1);
                            r_last <= f_is_last(w_next_addr, r_rem - LW'(1));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.t_o_valid = r_valid;
    assign bus.t_o_last  = r_last;
    assign bus.t_o_busy  = !w_idle;
    assign bus.t_o_err   = r_err;
endmodule

`default_nettype wire

// File: tb/tb_instr_stream.sv
// ============================================================================
// tb_instr_stream : scoreboard bench driving a WRAP=1 and a WRAP=0 instance
//                   (DEPTH=8) with identical stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_stream;
    logic t_clk = 1'b0;
    logic t_rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_err  = 0;
    int   err_cnt [2] = '{0, 0};

    always #5 t_clk = ~t_clk;

    instr_stream_if #(.IWIDTH(32), .AW(4), .LW(8)) ifa ();
    instr_stream_if #(.IWIDTH(32), .AW(4), .LW(8)) ifb ();

    assign ifb.t_i_req     = ifa.t_i_req;
    assign ifb.t_i_base    = ifa.t_i_base;
    assign ifb.t_i_len     = ifa.t_i_len;
    assign ifb.t_i_abort   = ifa.t_i_abort;
    assign ifb.t_i_ready   = ifa.t_i_ready;
    assign ifb.t_i_wr_en   = ifa.t_i_wr_en;
    assign ifb.t_i_wr_addr = ifa.t_i_wr_addr;
    assign ifb.t_i_wr_data = ifa.t_i_wr_data;

    instr_stream #(.IWIDTH(32), .DEPTH(8), .AW(4), .LW(8), .WRAP(1), .INIT_FILE("")) u_wrap (
        .t_clk (t_clk), .t_rst (t_rst), .bus (ifa.slave));
    instr_stream #(.IWIDTH(32), .DEPTH(8), .AW(4), .LW(8), .WRAP(0), .INIT_FILE("")) u_trunc (
        .t_clk (t_clk), .t_rst (t_rst), .bus (ifb.slave));

    logic [31:0] mon_instr [2];
    logic        mon_valid [2];
    logic        mon_last  [2];
    logic        mon_err   [2];
    assign mon_instr[0] = ifa.t_o_instr;  assign mon_instr[1] = ifb.t_o_instr;
    assign mon_valid[0] = ifa.t_o_valid;  assign mon_valid[1] = ifb.t_o_valid;
    assign mon_last[0]  = ifa.t_o_last;   assign mon_last[1]  = ifb.t_o_last;
    assign mon_err[0]   = ifa.t_o_err;    assign mon_err[1]   = ifb.t_o_err;

    // Expected beats per instance, packed as {last, word}.
    logic [32:0] exp_q [2][$];
    logic        prev_hold  [2] = '{1'b0, 1'b0};
    logic [32:0] prev_beat  [2];

    always @(negedge t_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (t_rst && prev_hold[d]) begin
                checks++;
                if (!mon_valid[d] || {mon_last[d], mon_instr[d]} != prev_beat[d]) begin
                    failures++;
                    $display("FAIL hold dut%0d actual valid=%b last=%b instr=%h required valid=1 beat=%h",
                             d, mon_valid[d], mon_last[d], mon_instr[d], prev_beat[d]);
                end
            end
            if (t_rst && mon_valid[d] && ifa.t_i_ready && !ifa.t_i_abort) begin
                checks++;
                if (exp_q[d].size() == 0) begin
                    failures++;
                    $display("FAIL beat dut%0d actual last=%b instr=%h required no beat",
                             d, mon_last[d], mon_instr[d]);
                end else begin
                    logic [32:0] e;
                    e = exp_q[d].pop_front();
                    if ({mon_last[d], mon_instr[d]} != e) begin
                        failures++;
                        $display("FAIL beat dut%0d actual last=%b instr=%h required last=%b instr=%h",
                                 d, mon_last[d], mon_instr[d], e[32], e[31:0]);
                    end
                end
            end
            prev_hold[d] = t_rst && mon_valid[d] && !ifa.t_i_ready && !ifa.t_i_abort;
            prev_beat[d] = {mon_last[d], mon_instr[d]};
            if (t_rst && mon_err[d]) err_cnt[d]++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic last, input logic [31:0] word);
        exp_q[0].push_back({last, word});
        exp_q[1].push_back({last, word});
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] b, input logic [7:0] l);
        ifa.t_i_base = b;
        ifa.t_i_len  = l;
        ifa.t_i_req  = 1'b1;
        tick();
        ifa.t_i_req  = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [31:0] w);
        ifa.t_i_wr_addr = a;
        ifa.t_i_wr_data = w;
        ifa.t_i_wr_en   = 1'b1;
        tick();
        ifa.t_i_wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((ifa.t_o_busy || ifb.t_o_busy) && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'(n < 50), 64'd1);
        tick();
        chk({name, "_drain_wrap"},  64'(exp_q[0].size()), 64'd0);
        chk({name, "_drain_trunc"}, 64'(exp_q[1].size()), 64'd0);
    endtask

    task automatic expect_err(input string name);
        exp_err++;
        chk({name, "_err_hi"}, {62'd0, ifa.t_o_err, ifb.t_o_err}, 64'h3);
        chk({name, "_busy"},   {62'd0, ifa.t_o_busy, ifb.t_o_busy}, 64'h0);
        tick();
        chk({name, "_err_lo"}, {62'd0, ifa.t_o_err, ifb.t_o_err}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        t_rst           = 1'b1;
        ifa.t_i_req     = 1'b0;
        ifa.t_i_base    = '0;
        ifa.t_i_len     = '0;
        ifa.t_i_abort   = 1'b0;
        ifa.t_i_ready   = 1'b0;
        ifa.t_i_wr_en   = 1'b0;
        ifa.t_i_wr_addr = '0;
        ifa.t_i_wr_data = '0;
        #1 t_rst = 1'b0;
        #1;
        chk("rst_wrap",  {ifa.t_o_instr, ifa.t_o_valid, ifa.t_o_last, ifa.t_o_busy, ifa.t_o_err}, 64'd0);
        chk("rst_trunc", {ifb.t_o_instr, ifb.t_o_valid, ifb.t_o_last, ifb.t_o_busy, ifb.t_o_err}, 64'd0);
        tick();
        tick();
        t_rst = 1'b1;

        for (int i = 0; i < 8; i++) write_word(4'(i), 32'h100 + 32'(i));

        // Basic burst with first-beat latency
        ifa.t_i_ready = 1'b1;
        push(1'b0, 32'h102); push(1'b0, 32'h103); push(1'b1, 32'h104);
        pulse_req(4'd2, 8'd3);
        chk("lat_accept", {62'd0, ifa.t_o_valid, ifa.t_o_busy}, 64'h1);
        tick();
        chk("lat_first", {ifa.t_o_valid, ifa.t_o_instr}, {1'b1, 32'h102});
        wait_idle("basic");

        // Backpressure 1,0,0,1,1
        ifa.t_i_ready = 1'b0;
        push(1'b0, 32'h102); push(1'b0, 32'h103); push(1'b1, 32'h104);
        pat = 5'b11001;
        pulse_req(4'd2, 8'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            ifa.t_i_ready = pat[i];
            tick();
        end
        ifa.t_i_ready = 1'b1;
        wait_idle("bp");

        // Wrap versus truncate
        exp_q[0].push_back({1'b0, 32'h106}); exp_q[0].push_back({1'b0, 32'h107});
        exp_q[0].push_back({1'b0, 32'h100}); exp_q[0].push_back({1'b1, 32'h101});
        exp_q[1].push_back({1'b0, 32'h106}); exp_q[1].push_back({1'b1, 32'h107});
        pulse_req(4'd6, 8'd4);
        wait_idle("wrap");

        // Bad requests and bad write address
        pulse_req(4'd2, 8'd0);
        expect_err("len0");
        pulse_req(4'd8, 8'd2);
        expect_err("base8");
        write_word(4'd8, 32'hBAD0BAD0);
        expect_err("wraddr8");

        // Write and request in the same idle cycle
        push(1'b1, 32'hDEADBEEF);
        ifa.t_i_wr_addr = 4'd3;
        ifa.t_i_wr_data = 32'hDEADBEEF;
        ifa.t_i_wr_en   = 1'b1;
        ifa.t_i_base    = 4'd3;
        ifa.t_i_len     = 8'd1;
        ifa.t_i_req     = 1'b1;
        tick();
        ifa.t_i_wr_en   = 1'b0;
        ifa.t_i_req     = 1'b0;
        wait_idle("wr_req");

        // Write while busy is dropped
        ifa.t_i_ready = 1'b0;
        push(1'b0, 32'h100); push(1'b1, 32'h101);
        pulse_req(4'd0, 8'd2);
        ifa.t_i_wr_addr = 4'd0;
        ifa.t_i_wr_data = 32'h12345678;
        ifa.t_i_wr_en   = 1'b1;
        tick();
        ifa.t_i_wr_en   = 1'b0;
        exp_err++;
        chk("wr_busy_err", {62'd0, ifa.t_o_err, ifb.t_o_err}, 64'h3);
        ifa.t_i_ready = 1'b1;
        wait_idle("wr_busy");
        push(1'b1, 32'h100);
        pulse_req(4'd0, 8'd1);
        wait_idle("mem_kept");

        // Abort on the third beat
        push(1'b0, 32'h100); push(1'b0, 32'h101);
        pulse_req(4'd0, 8'd5);
        tick();
        tick();
        tick();
        ifa.t_i_abort = 1'b1;
        tick();
        ifa.t_i_abort = 1'b0;
        chk("abort_wrap",  {61'd0, ifa.t_o_valid, ifa.t_o_last, ifa.t_o_busy}, 64'd0);
        chk("abort_trunc", {61'd0, ifb.t_o_valid, ifb.t_o_last, ifb.t_o_busy}, 64'd0);
        wait_idle("abort");

        // Asynchronous reset mid-burst
        push(1'b0, 32'h104);
        pulse_req(4'd4, 8'd4);
        tick();
        tick();
        t_rst = 1'b0;
        #1;
        chk("arst_wrap",  {ifa.t_o_instr, ifa.t_o_valid, ifa.t_o_last, ifa.t_o_busy, ifa.t_o_err}, 64'd0);
        chk("arst_trunc", {ifb.t_o_instr, ifb.t_o_valid, ifb.t_o_last, ifb.t_o_busy, ifb.t_o_err}, 64'd0);
        tick();
        t_rst = 1'b1;
        wait_idle("arst");
        push(1'b0, 32'h105); push(1'b1, 32'h106);
        pulse_req(4'd5, 8'd2);
        wait_idle("restart");

        chk("err_count_wrap",  64'(err_cnt[0]), 64'(exp_err));
        chk("err_count_trunc", 64'(err_cnt[1]), 64'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
